// File: rtl/ehr_fifo_if.sv
// ehr_fifo_if: enqueue/dequeue handshake bundle for ehr_fifo.
//   enq_en/enq_data/enq_rdy : producer side request, payload, accept
//   deq_en/deq_data/deq_rdy : consumer side request, head payload, accept
//   clr                     : synchronous flush request
//   count                   : current occupancy
// master drives requests (pipeline stage side); slave is the FIFO.
interface ehr_fifo_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             enq_en;
    logic [WIDTH-1:0] enq_data;
    logic             enq_rdy;
    logic             deq_en;
    logic [WIDTH-1:0] deq_data;
    logic             deq_rdy;
    logic             clr;
    logic [CW-1:0]    count;

    modport master (
        output enq_en, enq_data, deq_en, clr,
        input  enq_rdy, deq_data, deq_rdy, count
    );

    modport slave (
        input  enq_en, enq_data, deq_en, clr,
        output enq_rdy, deq_data, deq_rdy, count
    );
endinterface

// File: rtl/ehr_fifo.sv
// ehr_fifo: depth-configurable FIFO with EHR-style enq/deq ordering.
//   MODE 0 pipeline      : deq ordered before enq (full FIFO accepts enq with deq)
//   MODE 1 bypass        : enq ordered before deq (empty FIFO passes data through)
//   MODE 2 conflict-free : enq and deq ports independent
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : synchronous active-low reset (pointers and count only)
//   bus   : ehr_fifo_if slave (enq/deq handshake, clr flush, count)
module ehr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MODE  = 0
) (
    input logic        clk,
    input logic        rst_n,
    ehr_fifo_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_enq_rdy;
    logic w_deq_rdy;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_bypass;
    logic w_enq_upd;
    logic w_deq_upd;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready generation; the cross terms give the EHR ordering per mode.
    always_comb begin
        w_enq_rdy = !w_full;
        w_deq_rdy = !w_empty;
        if (MODE == 0) begin
            w_enq_rdy = !w_full || (bus.deq_en && !w_empty);
        end else if (MODE == 1) begin
            w_deq_rdy = !w_empty || bus.enq_en;
        end
    end

    assign w_enq_fire = bus.enq_en && w_enq_rdy;
    assign w_deq_fire = bus.deq_en && w_deq_rdy;

    // Empty pass-through: the entry never lands in storage.
    assign w_bypass  = (MODE == 1) && w_empty && w_enq_fire && w_deq_fire;
    assign w_enq_upd = w_enq_fire && !w_bypass;
    assign w_deq_upd = w_deq_fire && !w_bypass;

    assign bus.enq_rdy  = w_enq_rdy;
    assign bus.deq_rdy  = w_deq_rdy;
    assign bus.count    = r_count;
    assign bus.deq_data = ((MODE == 1) && w_empty) ? bus.enq_data : r_mem[r_head];

    // Pointer/occupancy state; reset wins over clr, clr wins over traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_upd) begin
                r_tail <= next_ptr(r_tail);
            end
            if (w_deq_upd) begin
                r_head <= next_ptr(r_head);
            end
            if (w_enq_upd && !w_deq_upd) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq_upd && w_deq_upd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage is not reset; contents are only meaningful behind count.
    always_ff @(posedge clk) begin
        if (w_enq_upd) begin
            r_mem[r_tail] <= bus.enq_data;
        end
    end
endmodule

// File: tb/tb_ehr_fifo.sv
// tb_ehr_fifo: five ehr_fifo instances (mode/depth mix) driven by a directed
// preamble then random traffic, each checked against a queue-based model.
module tb_ehr_fifo;
    localparam int NI = 5;

    function automatic int unsigned dep_of(input int g);
        case (g)
            3:       return 3;
            4:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned mode_of(input int g);
        case (g)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI-1:0] drv_enq_en;
    logic [NI-1:0] drv_deq_en;
    logic [NI-1:0] drv_clr;
    logic [31:0]   drv_data  [NI];
    logic [NI-1:0] obs_enq_rdy;
    logic [NI-1:0] obs_deq_rdy;
    logic [31:0]   obs_data  [NI];
    logic [31:0]   obs_count [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ehr_fifo_if #(.WIDTH(32), .DEPTH(dep_of(g))) bus ();
        ehr_fifo #(.WIDTH(32), .DEPTH(dep_of(g)), .MODE(mode_of(g))) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign bus.enq_en   = drv_enq_en[g];
        assign bus.enq_data = drv_data[g];
        assign bus.deq_en   = drv_deq_en[g];
        assign bus.clr      = drv_clr[g];
        assign obs_enq_rdy[g] = bus.enq_rdy;
        assign obs_deq_rdy[g] = bus.deq_rdy;
        assign obs_data[g]    = bus.deq_data;
        assign obs_count[g]   = 32'(bus.count);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one queue per instance, ordering rules from the mode table.
    logic [31:0] mq [NI][$];

    task automatic eval_and_update();
        for (int g = 0; g < NI; g++) begin
            int          sz;
            int          d;
            int          m;
            bit          full;
            bit          empty;
            bit          er;
            bit          dr;
            bit          ef;
            bit          df;
            logic [31:0] dd;
            sz    = mq[g].size();
            d     = int'(dep_of(g));
            m     = int'(mode_of(g));
            full  = (sz == d);
            empty = (sz == 0);
            er    = !full;
            dr    = !empty;
            dd    = empty ? drv_data[g] : mq[g][0];
            if (m == 0) er = !full || (drv_deq_en[g] && !empty);
            if (m == 1) dr = !empty || drv_enq_en[g];
            check_eq($sformatf("g%0d.enq_rdy", g), 32'(obs_enq_rdy[g]), 32'(er));
            check_eq($sformatf("g%0d.deq_rdy", g), 32'(obs_deq_rdy[g]), 32'(dr));
            check_eq($sformatf("g%0d.count", g), obs_count[g], 32'(sz));
            if (dr) check_eq($sformatf("g%0d.deq_data", g), obs_data[g], dd);
            if (!rst_n) begin
                mq[g].delete();
            end else begin
                ef = drv_enq_en[g] && er;
                df = drv_deq_en[g] && dr;
                if (!(m == 1 && empty && ef && df)) begin
                    if (df) void'(mq[g].pop_front());
                    if (ef) mq[g].push_back(drv_data[g]);
                end
                if (drv_clr[g]) mq[g].delete();
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        eval_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input bit rst, input bit en, input bit de,
                             input logic [31:0] data, input bit cl);
        rst_n = !rst;
        for (int g = 0; g < NI; g++) begin
            drv_enq_en[g] = en;
            drv_deq_en[g] = de;
            drv_data[g]   = data;
            drv_clr[g]    = cl;
        end
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          de;
        logic [31:0] data;
        bit          cl;
    } vec_t;

    localparam int NV = 25;
    vec_t dir [NV] = '{
        '{0,0,0,32'h0,0},  '{0,1,0,32'h1,0},  '{0,1,0,32'h2,0},  '{0,1,0,32'h3,0},
        '{0,1,0,32'h4,0},  '{0,1,0,32'h9,0},  '{0,1,1,32'h5,0},  '{0,0,1,32'h0,0},
        '{0,0,1,32'h0,0},  '{0,0,1,32'h0,0},  '{0,0,1,32'h0,0},  '{0,0,1,32'h0,0},
        '{0,1,1,32'hA5,0}, '{0,1,0,32'h11,0}, '{0,1,0,32'h12,0}, '{0,1,1,32'h13,1},
        '{0,0,0,32'h0,0},  '{0,1,0,32'h21,0}, '{0,1,0,32'h22,0}, '{0,1,0,32'h23,0},
        '{1,0,0,32'h0,0},  '{0,0,0,32'h0,0},  '{0,1,0,32'h7,0},  '{0,1,1,32'h8,0},
        '{0,0,1,32'h0,0}
    };

    initial begin
        drive_all(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            drive_all(dir[i].rst, dir[i].en, dir[i].de, dir[i].data, dir[i].cl);
            cycle();
        end
        // Wrap test on the depth-3 instance: hold occupancy near 2 with cnt/~cnt pairs.
        for (int c = 0; c < 10; c++) begin
            drive_all(1'b0, 1'b1, (c >= 2), 32'(c), 1'b0);
            cycle();
            drive_all(1'b0, 1'b1, 1'b1, ~32'(c), 1'b0);
            cycle();
        end
        // Random traffic with per-instance bias phases to reach full/empty often.
        begin
            int bias [NI];
            for (int g = 0; g < NI; g++) bias[g] = 50;
            for (int t = 0; t < 3000; t++) begin
                if (t % 32 == 0) begin
                    for (int g = 0; g < NI; g++) bias[g] = 20 + 30 * int'($urandom_range(0, 2));
                end
                rst_n = ($urandom_range(0, 199) != 0);
                for (int g = 0; g < NI; g++) begin
                    drv_enq_en[g] = ($urandom_range(0, 99) < 32'(bias[g]));
                    drv_deq_en[g] = ($urandom_range(0, 99) < 32'(100 - bias[g]));
                    drv_data[g]   = $urandom;
                    drv_clr[g]    = ($urandom_range(0, 39) == 0);
                end
                cycle();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
